// File: rtl/ddr_access_arbiter.sv
// Arbitrates the single DDR controller command port between display reads,
// drawing writes and periodic auto-refresh, one command in flight at a time.
module ddr_access_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int DATA_W           = 32,
    parameter int REFRESH_INTERVAL = 1000,
    parameter int MAX_OWED         = 8,
    parameter int MAX_RD_STREAK    = 4
) (
    input  logic                              clk133_p,
    input  logic                              rst,
    input  logic                              ddrInitDone,
    // Requesters: req is a level held until its ack; the ack is the accept.
    input  logic                              rdReq,
    input  logic [ADDR_W-1:0]                 rdAddr,
    output logic                              rdAck,
    output logic [DATA_W-1:0]                 rdData,
    output logic                              rdDataValid,
    input  logic                              wrReq,
    input  logic [ADDR_W-1:0]                 wrAddr,
    input  logic [DATA_W-1:0]                 wrData,
    output logic                              wrAck,
    // Controller: a command transfers on a cycle with cmdValid && cmdReady;
    // cmdOp/cmdAddr/cmdData hold steady while cmdValid waits for cmdReady.
    output logic                              cmdValid,
    input  logic                              cmdReady,
    output logic [1:0]                        cmdOp,
    output logic [ADDR_W-1:0]                 cmdAddr,
    output logic [DATA_W-1:0]                 cmdData,
    input  logic                              cmdDone,
    input  logic [DATA_W-1:0]                 ddrReadData,
    input  logic                              ddrReadValid,
    output logic                              refreshOverflow,
    // Debug view: state 0 INIT, 1 IDLE, 2 ISSUE, 3 WAIT; refresh credits owed.
    output logic [1:0]                        dbgState,
    output logic [$clog2(MAX_OWED+1)-1:0]     dbgOwed
);

    localparam int OWED_W   = $clog2(MAX_OWED + 1);
    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam int CNT_W    = $clog2(REFRESH_INTERVAL);

    localparam logic [OWED_W-1:0]   OWED_MAX   = OWED_W'(MAX_OWED);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
    localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_REFRESH = 2'b10;

    logic [1:0]          state_q, state_d;
    logic [OWED_W-1:0]   owed_q, owed_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    logic accept, acc_rd, acc_wr, acc_ref, expire;

    // Losing ddrInitDone aborts an offered command, so it also blocks the accept.
    assign accept  = cmd_valid_q && cmdReady && ddrInitDone;
    assign acc_rd  = accept && (cmd_op_q == OP_READ);
    assign acc_wr  = accept && (cmd_op_q == OP_WRITE);
    assign acc_ref = accept && (cmd_op_q == OP_REFRESH);
    assign expire  = (state_q != ST_INIT) && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (state_q == ST_INIT || expire) begin
            cnt_d = CNT_RELOAD;
        end
    end

    always_comb begin
        owed_d = owed_q;
        ovf_d  = ovf_q;
        if (expire && !acc_ref) begin
            if (owed_q == OWED_MAX) begin
                ovf_d = 1'b1;
            end else begin
                owed_d = owed_q + 1'b1;
            end
        end else if (acc_ref && !expire) begin
            owed_d = owed_q - 1'b1;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!wrReq || acc_wr) begin
            streak_d = '0;
        end else if (acc_rd && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        case (state_q)
            ST_INIT: begin
                if (ddrInitDone) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Refresh first, then a write starved by a read streak, then reads.
                if (owed_q != '0) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_REFRESH;
                    cmd_addr_d  = '0;
                    cmd_data_d  = '0;
                end else if (wrReq && (streak_q >= STREAK_MAX)) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_WRITE;
                    cmd_addr_d  = wrAddr;
                    cmd_data_d  = wrData;
                end else if (rdReq) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_READ;
                    cmd_addr_d  = rdAddr;
                    cmd_data_d  = '0;
                end else if (wrReq) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_WRITE;
                    cmd_addr_d  = wrAddr;
                    cmd_data_d  = wrData;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    state_d     = ST_WAIT;
                    cmd_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cmdDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (!ddrInitDone) begin
            state_d     = ST_INIT;
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk133_p or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            owed_q      <= '0;
            streak_q    <= '0;
            cnt_q       <= CNT_RELOAD;
            ovf_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 2'b00;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owed_q      <= owed_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            rd_data_q   <= ddrReadData;
            rd_valid_q  <= ddrReadValid;
        end
    end

    assign rdAck           = acc_rd;
    assign wrAck           = acc_wr;
    assign rdData          = rd_data_q;
    assign rdDataValid     = rd_valid_q;
    assign cmdValid        = cmd_valid_q;
    assign cmdOp           = cmd_op_q;
    assign cmdAddr         = cmd_addr_q;
    assign cmdData         = cmd_data_q;
    assign refreshOverflow = ovf_q;
    assign dbgState        = state_q;
    assign dbgOwed         = owed_q;

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Bench for ddr_access_arbiter: a cycle-level reference model checked every
// cycle, a controller responder, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_ddr_access_arbiter;

    localparam int ADDR_W        = 24;
    localparam int DATA_W        = 32;
    localparam int RI            = 1000;
    localparam int MAX_OWED      = 8;
    localparam int MAX_RD_STREAK = 4;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_REF  = 2'b10;
    localparam logic [1:0] ST_INIT = 2'd0;

    logic              clk133_p     = 1'b0;
    logic              rst          = 1'b1;
    logic              ddrInitDone  = 1'b0;
    logic              rdReq        = 1'b0;
    logic [ADDR_W-1:0] rdAddr       = '0;
    logic              wrReq        = 1'b0;
    logic [ADDR_W-1:0] wrAddr       = '0;
    logic [DATA_W-1:0] wrData       = '0;
    logic              cmdReady     = 1'b0;
    logic              cmdDone      = 1'b0;
    logic [DATA_W-1:0] ddrReadData  = '0;
    logic              ddrReadValid = 1'b0;

    logic              rdAck, rdDataValid, wrAck, cmdValid, refreshOverflow;
    logic [DATA_W-1:0] rdData, cmdData;
    logic [ADDR_W-1:0] cmdAddr;
    logic [1:0]        cmdOp, dbgState;
    logic [3:0]        dbgOwed;

    ddr_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_INTERVAL(RI),
        .MAX_OWED(MAX_OWED), .MAX_RD_STREAK(MAX_RD_STREAK)
    ) dut (
        .clk133_p(clk133_p), .rst(rst), .ddrInitDone(ddrInitDone),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(rdAck),
        .rdData(rdData), .rdDataValid(rdDataValid),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
        .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdDone(cmdDone),
        .ddrReadData(ddrReadData), .ddrReadValid(ddrReadValid),
        .refreshOverflow(refreshOverflow), .dbgState(dbgState), .dbgOwed(dbgOwed)
    );

    // ---------------- clock / reset ----------------
    always #3.75 clk133_p = ~clk133_p;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard storage ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        acc_q[$];
    int                wr_ack_seen = 0;

    // ---------------- controller responder ----------------
    logic              resp_en      = 1'b1;
    logic [DATA_W-1:0] resp_rd_data = 32'h0F0FF0F0;

    always @(negedge clk133_p) begin : responder
        logic is_rd;
        if (rst && resp_en && cmdValid && cmdReady && ddrInitDone) begin
            is_rd = (cmdOp == OP_RD);
            @(posedge clk133_p); #1;
            @(posedge clk133_p); #1;
            cmdDone = 1'b1;
            if (is_rd) begin
                ddrReadValid = 1'b1;
                ddrReadData  = resp_rd_data;
                exp_q.push_back(resp_rd_data);
                resp_rd_data = resp_rd_data + 32'h01010101;
            end
            @(posedge clk133_p); #1;
            cmdDone      = 1'b0;
            ddrReadValid = 1'b0;
            ddrReadData  = '0;
        end
    end

    // ---------------- reference model + compare ----------------
    logic              m_init, m_valid, m_busy, m_ovf, m_rvalid;
    logic [1:0]        m_op;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data, m_rdata;
    int                m_owed, m_streak, m_ticks;

    always @(negedge clk133_p) begin : compare
        logic acc, expire;
        int   owed_n;
        if (!rst) begin
            check("rst_cmdValid", 64'(cmdValid), 64'(0));
            check("rst_rdAck", 64'(rdAck), 64'(0));
            check("rst_wrAck", 64'(wrAck), 64'(0));
            check("rst_rdDataValid", 64'(rdDataValid), 64'(0));
            check("rst_rdData", 64'(rdData), 64'(0));
            check("rst_cmdOp", 64'(cmdOp), 64'(0));
            check("rst_cmdAddr", 64'(cmdAddr), 64'(0));
            check("rst_cmdData", 64'(cmdData), 64'(0));
            check("rst_overflow", 64'(refreshOverflow), 64'(0));
            check("rst_owed", 64'(dbgOwed), 64'(0));
            check("rst_state", 64'(dbgState), 64'(ST_INIT));
            m_init = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
            m_op = OP_RD; m_addr = '0; m_data = '0;
            m_owed = 0; m_streak = 0; m_ticks = 0;
            m_rvalid = 1'b0; m_rdata = '0;
        end else begin
            acc = m_valid && cmdReady && ddrInitDone;
            check("cmdValid", 64'(cmdValid), 64'(m_valid));
            check("rdAck", 64'(rdAck), 64'(acc && m_op == OP_RD));
            check("wrAck", 64'(wrAck), 64'(acc && m_op == OP_WR));
            check("rdDataValid", 64'(rdDataValid), 64'(m_rvalid));
            check("rdData", 64'(rdData), 64'(m_rdata));
            check("refreshOverflow", 64'(refreshOverflow), 64'(m_ovf));
            check("owed", 64'(dbgOwed), 64'(m_owed));
            if (m_valid) begin
                check("cmdOp", 64'(cmdOp), 64'(m_op));
                check("cmdAddr", 64'(cmdAddr), 64'(m_addr));
                check("cmdData", 64'(cmdData), 64'(m_data));
            end
            if (rdDataValid) begin
                if (exp_q.size() == 0) check("rd_return_unexpected", 64'(1), 64'(0));
                else check("rd_return_data", 64'(rdData), 64'(exp_q.pop_front()));
            end
            if (cmdValid && cmdReady && ddrInitDone) acc_q.push_back(cmdOp);
            if (wrAck) wr_ack_seen++;

            // advance the model by one clock
            m_rvalid = ddrReadValid;
            m_rdata  = ddrReadData;
            expire   = 1'b0;
            if (!m_init) begin
                m_ticks++;
                expire = (m_ticks % RI) == 0;
            end
            owed_n = m_owed + (expire ? 1 : 0) - ((acc && m_op == OP_REF) ? 1 : 0);
            if (owed_n > MAX_OWED) begin
                owed_n = MAX_OWED;
                m_ovf  = 1'b1;
            end
            if (m_init) begin
                m_ticks = 0;
                if (ddrInitDone) m_init = 1'b0;
            end else if (!ddrInitDone) begin
                m_init = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_ticks = 0;
            end else if (m_valid) begin
                if (acc) begin m_valid = 1'b0; m_busy = 1'b1; end
            end else if (m_busy) begin
                if (cmdDone) m_busy = 1'b0;
            end else if (m_owed > 0) begin
                m_valid = 1'b1; m_op = OP_REF; m_addr = '0; m_data = '0;
            end else if (wrReq && m_streak >= MAX_RD_STREAK) begin
                m_valid = 1'b1; m_op = OP_WR; m_addr = wrAddr; m_data = wrData;
            end else if (rdReq) begin
                m_valid = 1'b1; m_op = OP_RD; m_addr = rdAddr; m_data = '0;
            end else if (wrReq) begin
                m_valid = 1'b1; m_op = OP_WR; m_addr = wrAddr; m_data = wrData;
            end
            if (!wrReq || (acc && m_op == OP_WR)) m_streak = 0;
            else if (acc && m_op == OP_RD && m_streak < MAX_RD_STREAK) m_streak++;
            m_owed = owed_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk133_p); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic sample();
        @(negedge clk133_p);
    endtask

    task automatic wait_accepts(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (acc_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        check(name, 64'(acc_q.size()), 64'(n));
    endtask

    logic [1:0] exp_order [10];

    initial begin
        exp_order = '{OP_RD, OP_RD, OP_RD, OP_RD, OP_WR, OP_RD, OP_RD, OP_RD, OP_RD, OP_WR};
        #1 rst = 1'b0;
        ticks(3);
        sample();
        check("reset_state_init", 64'(dbgState), 64'(ST_INIT));

        // Init gating, first read with data return
        tick();
        rst = 1'b1; rdReq = 1'b1; rdAddr = 24'h012345;
        ticks(50);
        sample();
        check("init_hold_cmdValid", 64'(cmdValid), 64'(0));
        check("init_hold_owed", 64'(dbgOwed), 64'(0));
        tick();
        ddrInitDone = 1'b1; cmdReady = 1'b1;
        sample();
        check("c0_cmdValid", 64'(cmdValid), 64'(0));
        tick(); sample();
        check("c1_cmdValid", 64'(cmdValid), 64'(0));
        tick(); sample();
        check("c2_cmdValid", 64'(cmdValid), 64'(1));
        check("c2_cmdOp_read", 64'(cmdOp), 64'(OP_RD));
        check("c2_cmdAddr", 64'(cmdAddr), 64'h012345);
        check("c2_rdAck", 64'(rdAck), 64'(1));
        tick();
        rdReq = 1'b0;
        sample();
        check("c3_rdAck_pulse", 64'(rdAck), 64'(0));
        check("c3_cmdValid_fall", 64'(cmdValid), 64'(0));
        tick(); sample();
        check("c4_rdDataValid", 64'(rdDataValid), 64'(0));
        tick(); sample();
        check("c5_rdDataValid", 64'(rdDataValid), 64'(1));
        check("c5_rdData", 64'(rdData), 64'h0F0FF0F0);
        tick(); sample();
        check("c6_rdDataValid", 64'(rdDataValid), 64'(0));

        // Read streak vs pending write
        tick();
        acc_q.delete();
        rdReq = 1'b1; rdAddr = 24'h000100;
        wrReq = 1'b1; wrAddr = 24'h000200; wrData = 32'hDEADBEEF;
        wait_accepts(10, 300, "grant_order_count");
        rdReq = 1'b0; wrReq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < acc_q.size()) check($sformatf("grant_order_%0d", i), 64'(acc_q[i]), 64'(exp_order[i]));
        end
        ticks(10);

        // Refresh timing, saturation and drain
        rst = 1'b0; ddrInitDone = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();
        ddrInitDone = 1'b1; cmdReady = 1'b1;
        acc_q.delete();
        ticks(1001); sample();
        check("ref_not_yet", 64'(cmdValid), 64'(0));
        tick(); sample();
        check("ref_offer_valid", 64'(cmdValid), 64'(1));
        check("ref_offer_op", 64'(cmdOp), 64'(OP_REF));
        check("ref_offer_addr", 64'(cmdAddr), 64'(0));
        ticks(8);
        check("ref_count_one", 64'(acc_q.size()), 64'(1));
        cmdReady = 1'b0;
        ticks(4000);
        rdReq = 1'b1; rdAddr = 24'h0ABCDE;
        ticks(5000); sample();
        check("sat_owed", 64'(dbgOwed), 64'(MAX_OWED));
        check("sat_overflow", 64'(refreshOverflow), 64'(1));
        check("sat_stalled_op", 64'(cmdOp), 64'(OP_REF));
        tick();
        acc_q.delete();
        cmdReady = 1'b1;
        wait_accepts(9, 300, "drain_count");
        rdReq = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < acc_q.size()) check($sformatf("drain_order_%0d", i), 64'(acc_q[i]), 64'(i < 8 ? OP_REF : OP_RD));
        end
        ticks(10);

        // Reset in the middle of a stalled write
        rst = 1'b0;
        ticks(2);
        rst = 1'b1; ddrInitDone = 1'b1; cmdReady = 1'b0;
        wrReq = 1'b1; wrAddr = 24'h00BEEF; wrData = 32'h5555AAAA;
        wr_ack_seen = 0;
        ticks(2); sample();
        check("wr_offer_valid", 64'(cmdValid), 64'(1));
        check("wr_offer_op", 64'(cmdOp), 64'(OP_WR));
        check("wr_offer_data", 64'(cmdData), 64'h5555AAAA);
        tick();
        rst = 1'b0;
        sample();
        check("midreset_cmdValid", 64'(cmdValid), 64'(0));
        ticks(2);
        rst = 1'b1;
        sample();
        check("after_reset_state", 64'(dbgState), 64'(ST_INIT));
        ticks(5);
        check("no_wrAck", 64'(wr_ack_seen), 64'(0));
        check("rd_returns_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
